// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic-cycle master for the Nysa command bus.
// Runs single or burst read/write commands from an internal controller.
// Write data streams in on i_wr_*. Read data streams out on o_rd_*.
// Completion is reported on o_done. An ack timeout is flagged on o_timeout.
// Ports:
//   clk, rst (async, active-low)
//   i_cmd_stb/we/adr/len, o_cmd_rdy    : command handshake
//   i_wr_dat/vld, o_wr_rdy             : write-data stream in
//   o_rd_dat/vld                       : read-data stream out (no backpressure)
//   o_done, o_timeout                  : completion / abort status
//   o_wbm_cyc/stb/we/sel/adr/dat,
//   i_wbm_dat/ack/int                  : Wishbone master side
//   o_int                              : i_wbm_int registered once
module wb_cmd_master #(
    parameter int unsigned ADDR_INC = 1,
    parameter int unsigned TIMEOUT  = 256,
    parameter int unsigned TW       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_stb,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_adr,
    input  logic [15:0] i_cmd_len,
    output logic        o_cmd_rdy,
    input  logic [31:0] i_wr_dat,
    input  logic        i_wr_vld,
    output logic        o_wr_rdy,
    output logic [31:0] o_rd_dat,
    output logic        o_rd_vld,
    output logic        o_done,
    output logic        o_timeout,
    output logic        o_wbm_cyc,
    output logic        o_wbm_stb,
    output logic        o_wbm_we,
    output logic [3:0]  o_wbm_sel,
    output logic [31:0] o_wbm_adr,
    output logic [31:0] o_wbm_dat,
    input  logic [31:0] i_wbm_dat,
    input  logic        i_wbm_ack,
    input  logic        i_wbm_int,
    output logic        o_int
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WDATA = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_REL   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] ADR_STEP = AW'(ADDR_INC);

    logic [2:0]    r_state,   w_state;
    logic          r_cmd_rdy, w_cmd_rdy;
    logic          r_we_cmd,  w_we_cmd;
    logic [LW-1:0] r_rem,     w_rem;
    logic [TW-1:0] r_timer,   w_timer;
    logic          r_cyc,     w_cyc;
    logic          r_stb,     w_stb;
    logic          r_wbm_we,  w_wbm_we;
    logic [3:0]    r_sel;
    logic [AW-1:0] r_adr,     w_adr;
    logic [DW-1:0] r_wdat,    w_wdat;
    logic [DW-1:0] r_rd_dat,  w_rd_dat;
    logic          r_rd_vld,  w_rd_vld;
    logic          r_done,    w_done;
    logic          r_timeout, w_timeout;
    logic          r_int;
    logic          w_accept;

    // o_cmd_rdy is only ever high while the FSM sits in IDLE
    assign w_accept = i_cmd_stb && r_cmd_rdy;

    // Next-state and next-output logic
    always_comb begin
        w_state   = r_state;
        w_cmd_rdy = 1'b0;
        w_we_cmd  = r_we_cmd;
        w_rem     = r_rem;
        w_timer   = r_timer;
        w_cyc     = r_cyc;
        w_stb     = r_stb;
        w_wbm_we  = r_wbm_we;
        w_adr     = r_adr;
        w_wdat    = r_wdat;
        w_rd_dat  = r_rd_dat;
        w_rd_vld  = 1'b0;
        w_timeout = r_timeout;
        w_done    = (r_state == ST_DONE);

        case (r_state)
            ST_IDLE: begin
                // Ready shows one cycle after entering IDLE, so it trails o_done
                w_cmd_rdy = 1'b1;
                if (w_accept) begin
                    w_cmd_rdy = 1'b0;
                    w_we_cmd  = i_cmd_we;
                    w_adr     = i_cmd_adr;
                    w_rem     = i_cmd_len;
                    w_timeout = 1'b0;
                    w_timer   = '0;
                    if (i_cmd_len == '0) begin
                        w_state = ST_DONE;
                    end else if (i_cmd_we) begin
                        w_state = ST_WDATA;
                    end else begin
                        w_cyc    = 1'b1;
                        w_stb    = 1'b1;
                        w_wbm_we = 1'b0;
                        w_state  = ST_REQ;
                    end
                end
            end

            ST_WDATA: begin
                // cyc stays as it was; stb waits for data
                if (i_wr_vld) begin
                    w_wdat   = i_wr_dat;
                    w_cyc    = 1'b1;
                    w_stb    = 1'b1;
                    w_wbm_we = 1'b1;
                    w_timer  = '0;
                    w_state  = ST_REQ;
                end
            end

            ST_REQ: begin
                w_timer = r_timer + TW'(1);
                // Ack takes priority over a timeout expiring in the same cycle
                if (i_wbm_ack) begin
                    w_stb = 1'b0;
                    if (!r_we_cmd) begin
                        w_rd_dat = i_wbm_dat;
                        w_rd_vld = 1'b1;
                    end
                    w_rem   = r_rem - LW'(1);
                    w_adr   = r_adr + ADR_STEP;
                    w_timer = '0;
                    w_state = ST_REL;
                end else if (r_timer == TMO_LAST) begin
                    w_cyc     = 1'b0;
                    w_stb     = 1'b0;
                    w_wbm_we  = 1'b0;
                    w_timeout = 1'b1;
                    w_state   = ST_DONE;
                end
            end

            ST_REL: begin
                // A high ack here is the previous word's ack, still held by the slave
                if (!i_wbm_ack) begin
                    w_timer = '0;
                    if (r_rem == '0) begin
                        w_cyc    = 1'b0;
                        w_wbm_we = 1'b0;
                        w_state  = ST_DONE;
                    end else if (r_we_cmd) begin
                        w_state = ST_WDATA;
                    end else begin
                        w_stb   = 1'b1;
                        w_state = ST_REQ;
                    end
                end else if (r_timer == TMO_LAST) begin
                    w_cyc     = 1'b0;
                    w_stb     = 1'b0;
                    w_wbm_we  = 1'b0;
                    w_timeout = 1'b1;
                    w_state   = ST_DONE;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end

            ST_DONE: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cmd_rdy <= 1'b0;
            r_we_cmd  <= 1'b0;
            r_rem     <= '0;
            r_timer   <= '0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_wbm_we  <= 1'b0;
            r_sel     <= 4'h0;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_rd_dat  <= '0;
            r_rd_vld  <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_int     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cmd_rdy <= w_cmd_rdy;
            r_we_cmd  <= w_we_cmd;
            r_rem     <= w_rem;
            r_timer   <= w_timer;
            r_cyc     <= w_cyc;
            r_stb     <= w_stb;
            r_wbm_we  <= w_wbm_we;
            r_sel     <= w_cyc ? 4'hF : 4'h0;
            r_adr     <= w_adr;
            r_wdat    <= w_wdat;
            r_rd_dat  <= w_rd_dat;
            r_rd_vld  <= w_rd_vld;
            r_done    <= w_done;
            r_timeout <= w_timeout;
            r_int     <= i_wbm_int;
        end
    end

    assign o_cmd_rdy = r_cmd_rdy;
    assign o_wr_rdy  = (r_state == ST_WDATA);
    assign o_rd_dat  = r_rd_dat;
    assign o_rd_vld  = r_rd_vld;
    assign o_done    = r_done;
    assign o_timeout = r_timeout;
    assign o_wbm_cyc = r_cyc;
    assign o_wbm_stb = r_stb;
    assign o_wbm_we  = r_wbm_we;
    assign o_wbm_sel = r_sel;
    assign o_wbm_adr = r_adr;
    assign o_wbm_dat = r_wdat;
    assign o_int     = r_int;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: user-slave style Wishbone slave model plus
// per-command reference expectations derived from command fields.
`timescale 1ns/1ps
module tb_wb_cmd_master;

    localparam int unsigned TMO = 16;
    localparam int unsigned INC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_cmd_stb, i_cmd_we;
    logic [31:0] i_cmd_adr;
    logic [15:0] i_cmd_len;
    logic        o_cmd_rdy;
    logic [31:0] i_wr_dat;
    logic        i_wr_vld, o_wr_rdy;
    logic [31:0] o_rd_dat;
    logic        o_rd_vld, o_done, o_timeout;
    logic        o_wbm_cyc, o_wbm_stb, o_wbm_we;
    logic [3:0]  o_wbm_sel;
    logic [31:0] o_wbm_adr, o_wbm_dat;
    logic [31:0] i_wbm_dat;
    logic        i_wbm_ack, i_wbm_int, o_int;

    int n_cmp = 0;
    int n_err = 0;

    // Slave behaviour: 0 normal, 1 never acks, 2 holds ack forever
    int s_mode = 0;
    int s_dly  = 0;
    int s_rel  = 0;
    int s_cnt;

    logic [31:0] q_wdat [0:15];
    int          q_gap  [0:15];

    always #5 clk = ~clk;

    wb_cmd_master #(.ADDR_INC(INC), .TIMEOUT(TMO), .TW(16)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_stb(i_cmd_stb), .i_cmd_we(i_cmd_we), .i_cmd_adr(i_cmd_adr),
        .i_cmd_len(i_cmd_len), .o_cmd_rdy(o_cmd_rdy),
        .i_wr_dat(i_wr_dat), .i_wr_vld(i_wr_vld), .o_wr_rdy(o_wr_rdy),
        .o_rd_dat(o_rd_dat), .o_rd_vld(o_rd_vld), .o_done(o_done),
        .o_timeout(o_timeout),
        .o_wbm_cyc(o_wbm_cyc), .o_wbm_stb(o_wbm_stb), .o_wbm_we(o_wbm_we),
        .o_wbm_sel(o_wbm_sel), .o_wbm_adr(o_wbm_adr), .o_wbm_dat(o_wbm_dat),
        .i_wbm_dat(i_wbm_dat), .i_wbm_ack(i_wbm_ack), .i_wbm_int(i_wbm_int),
        .o_int(o_int)
    );

    // Slave: acks after s_dly wait cycles, holds ack until it sees stb low,
    // read data is the bus address of the word
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_wbm_ack <= 1'b0;
            i_wbm_dat <= 32'h0;
            s_cnt     <= 0;
        end else if (i_wbm_ack) begin
            if (!o_wbm_stb && s_mode != 2) begin
                if (s_cnt >= s_rel) begin
                    i_wbm_ack <= 1'b0;
                    s_cnt     <= 0;
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end
        end else if (o_wbm_cyc && o_wbm_stb && s_mode != 1) begin
            if (s_cnt >= s_dly) begin
                i_wbm_ack <= 1'b1;
                i_wbm_dat <= o_wbm_adr;
                s_cnt     <= 0;
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end else begin
            s_cnt <= 0;
        end
    end

    task automatic clear_wdata();
        for (int i = 0; i < 16; i++) begin
            q_wdat[i] = $urandom;
            q_gap[i]  = 0;
        end
    endtask

    // Issue one command and compare everything observed against expectations
    task automatic run_cmd(input string name, input logic we, input logic [31:0] adr,
                           input logic [15:0] len, input int mode);
        int c, n_wr, gap_left, stb_rises, cyc_falls, done_cnt, done_c, rdy_c;
        int stb_rise_c, cyc_fall_c, run, run_max, n_exp, n_pres;
        logic prev_stb, prev_cyc;
        bit fin;
        logic [31:0] tx_adr[$], tx_dat[$], rd_q[$];
        logic        tx_we[$];

        c = 0;
        while (!(o_cmd_rdy === 1'b1 && i_wbm_ack === 1'b0) && c < 60) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (c >= 60) begin
            n_err++;
            $display("FAIL %s idle_wait: rdy=%b ack=%b, want rdy=1 ack=0", name, o_cmd_rdy, i_wbm_ack);
        end
        s_mode = mode;
        n_wr = 0; gap_left = q_gap[0]; stb_rises = 0; cyc_falls = 0; done_cnt = 0;
        done_c = -1; rdy_c = -1; stb_rise_c = -1; cyc_fall_c = -1; run = 0; run_max = 0;
        prev_stb = o_wbm_stb; prev_cyc = o_wbm_cyc; fin = 0;

        i_cmd_stb = 1'b1; i_cmd_we = we; i_cmd_adr = adr; i_cmd_len = len;
        for (c = 0; c < 500; c++) begin
            if (c > 0) begin
                // Commands offered while busy must be ignored
                i_cmd_stb = !o_cmd_rdy && ($urandom_range(0, 2) == 0);
                i_cmd_we  = 1'($urandom);
                i_cmd_adr = $urandom;
                i_cmd_len = 16'($urandom);
            end
            if (we && n_wr < int'(len)) begin
                if (gap_left > 0) begin
                    i_wr_vld = 1'b0;
                    gap_left--;
                end else begin
                    i_wr_vld = 1'b1;
                    i_wr_dat = q_wdat[n_wr];
                end
            end else begin
                i_wr_vld = 1'($urandom);
                i_wr_dat = $urandom;
            end
            #1;
            if (o_wr_rdy) begin
                n_cmp++;
                if (o_wbm_stb !== 1'b0 || (n_wr > 0 && o_wbm_cyc !== 1'b1)) begin
                    n_err++;
                    $display("FAIL %s wdata_wait: cyc=%b stb=%b, want stb=0 cyc=%b", name,
                             o_wbm_cyc, o_wbm_stb, (n_wr > 0));
                end
                if (i_wr_vld) begin
                    n_wr++;
                    gap_left = (n_wr < 16) ? q_gap[n_wr] : 0;
                end
            end
            n_cmp++;
            if (o_wbm_sel !== (o_wbm_cyc ? 4'hF : 4'h0)) begin
                n_err++;
                $display("FAIL %s sel: got %h with cyc=%b", name, o_wbm_sel, o_wbm_cyc);
            end
            if (o_wbm_cyc && o_wbm_stb && i_wbm_ack) begin
                tx_adr.push_back(o_wbm_adr);
                tx_dat.push_back(o_wbm_dat);
                tx_we.push_back(o_wbm_we);
            end
            if (o_wbm_stb && !prev_stb) begin
                stb_rises++;
                if (stb_rise_c < 0) stb_rise_c = c;
            end
            if (!o_wbm_cyc && prev_cyc) begin
                cyc_falls++;
                cyc_fall_c = c;
            end
            run = o_wbm_stb ? run + 1 : 0;
            if (run > run_max) run_max = run;
            if (o_rd_vld) rd_q.push_back(o_rd_dat);
            if (o_done) begin
                done_cnt++;
                done_c = c;
            end
            if (c == 1) begin
                n_cmp++;
                if (o_timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s timeout_clear: got %b want 0", name, o_timeout);
                end
            end
            if (done_cnt > 0 && o_cmd_rdy) begin
                rdy_c = c;
                fin = 1;
            end
            prev_stb = o_wbm_stb;
            prev_cyc = o_wbm_cyc;
            if (fin) break;
            @(negedge clk);
        end
        i_cmd_stb = 1'b0;
        i_wr_vld  = 1'b0;
        s_mode    = 0;

        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL %s finish: command did not complete in 500 cycles", name);
            return;
        end

        n_exp  = (len == 0 || mode == 1) ? 0 : ((mode == 2) ? 1 : int'(len));
        n_pres = (len == 0) ? 0 : ((mode == 0) ? int'(len) : 1);

        n_cmp++;
        if (tx_adr.size() != n_exp) begin
            n_err++;
            $display("FAIL %s tx_count: got %0d want %0d", name, tx_adr.size(), n_exp);
        end
        for (int i = 0; i < tx_adr.size() && i < n_exp; i++) begin
            n_cmp++;
            if (tx_adr[i] !== adr + 32'(i * INC) || tx_we[i] !== we ||
                (we && tx_dat[i] !== q_wdat[i])) begin
                n_err++;
                $display("FAIL %s tx[%0d]: adr=%h we=%b dat=%h, want adr=%h we=%b dat=%h", name, i,
                         tx_adr[i], tx_we[i], tx_dat[i], adr + 32'(i * INC), we, q_wdat[i]);
            end
        end
        n_cmp++;
        if (rd_q.size() != (we ? 0 : n_exp)) begin
            n_err++;
            $display("FAIL %s rd_count: got %0d want %0d", name, rd_q.size(), we ? 0 : n_exp);
        end
        for (int i = 0; i < rd_q.size() && i < n_exp; i++) begin
            n_cmp++;
            if (rd_q[i] !== adr + 32'(i * INC)) begin
                n_err++;
                $display("FAIL %s rd[%0d]: got %h want %h", name, i, rd_q[i], adr + 32'(i * INC));
            end
        end
        n_cmp++;
        if (done_cnt != 1 || rdy_c != done_c + 1) begin
            n_err++;
            $display("FAIL %s done: count=%0d rdy_gap=%0d, want count=1 rdy_gap=1", name,
                     done_cnt, rdy_c - done_c);
        end
        n_cmp++;
        if (o_timeout !== (len != 0 && mode != 0)) begin
            n_err++;
            $display("FAIL %s timeout: got %b want %b", name, o_timeout, (len != 0 && mode != 0));
        end
        n_cmp++;
        if (stb_rises != n_pres || cyc_falls != ((len == 0) ? 0 : 1) ||
            n_wr != (we ? n_pres : 0)) begin
            n_err++;
            $display("FAIL %s shape: stb_rises=%0d cyc_falls=%0d wr_taken=%0d, want %0d %0d %0d",
                     name, stb_rises, cyc_falls, n_wr, n_pres, (len == 0) ? 0 : 1, we ? n_pres : 0);
        end
        if (len == 0) begin
            n_cmp++;
            if (done_c != 2) begin
                n_err++;
                $display("FAIL %s zero_len_latency: got %0d want 2", name, done_c);
            end
        end
        if (mode == 1 && len != 0) begin
            n_cmp++;
            if (cyc_fall_c - stb_rise_c != int'(TMO) || run_max != int'(TMO)) begin
                n_err++;
                $display("FAIL %s timeout_len: cyc_after=%0d stb_run=%0d want %0d", name,
                         cyc_fall_c - stb_rise_c, run_max, TMO);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({o_cmd_rdy, o_wr_rdy, o_rd_vld, o_done, o_timeout, o_wbm_cyc, o_wbm_stb,
             o_wbm_we, o_int} !== 9'b0 || o_wbm_sel !== 4'h0 || o_wbm_adr !== 32'h0 ||
            o_wbm_dat !== 32'h0 || o_rd_dat !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b cyc=%b stb=%b adr=%h, want all 0",
                     o_cmd_rdy, o_wbm_cyc, o_wbm_stb, o_wbm_adr);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_cmd_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rdy_before_edge: got %b want 0", o_cmd_rdy);
        end
        @(negedge clk);
        n_cmp++;
        if (o_cmd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy_after_edge: got %b want 1", o_cmd_rdy);
        end
    endtask

    task automatic test_single_write();
        clear_wdata();
        q_wdat[0] = 32'hDEADBEEF;
        s_dly = 0; s_rel = 0;
        run_cmd("single_write", 1'b1, 32'h2, 16'd1, 0);
    endtask

    task automatic test_burst_read();
        s_dly = 0; s_rel = 0;
        run_cmd("burst_read", 1'b0, 32'h0, 16'd3, 0);
    endtask

    task automatic test_timeout();
        run_cmd("timeout_read", 1'b0, 32'h100, 16'd1, 1);
        clear_wdata();
        run_cmd("timeout_write", 1'b1, 32'h200, 16'd2, 1);
    endtask

    task automatic test_zero_len();
        run_cmd("zero_len_rd", 1'b0, 32'h40, 16'd0, 0);
        run_cmd("zero_len_wr", 1'b1, 32'h44, 16'd0, 0);
    endtask

    task automatic test_wrap();
        s_dly = 1; s_rel = 1;
        run_cmd("wrap_read", 1'b0, 32'hFFFF_FFFF, 16'd2, 0);
    endtask

    task automatic test_write_gap();
        clear_wdata();
        q_gap[1] = 5;
        s_dly = 0; s_rel = 0;
        run_cmd("write_gap", 1'b1, 32'h1000, 16'd3, 0);
    endtask

    task automatic test_stuck_ack();
        s_dly = 0; s_rel = 0;
        run_cmd("stuck_ack_rd", 1'b0, 32'h300, 16'd3, 2);
        clear_wdata();
        run_cmd("stuck_ack_wr", 1'b1, 32'h310, 16'd1, 2);
    endtask

    task automatic test_int();
        logic prev;
        prev = o_int;
        for (int i = 0; i < 12; i++) begin
            i_wbm_int = 1'($urandom);
            prev = i_wbm_int;
            @(negedge clk);
            n_cmp++;
            if (o_int !== prev) begin
                n_err++;
                $display("FAIL int[%0d]: got %b want %b", i, o_int, prev);
            end
        end
        i_wbm_int = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        we;
        logic [31:0] adr;
        logic [15:0] len;
        int          r, mode;
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom);
            adr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
            len  = 16'($urandom_range(0, 5));
            r    = $urandom_range(0, 9);
            mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            s_dly = $urandom_range(0, 3);
            s_rel = $urandom_range(0, 2);
            clear_wdata();
            for (int k = 0; k < 16; k++) q_gap[k] = $urandom_range(0, 3);
            run_cmd("random", we, adr, len, mode);
        end
    endtask

    task automatic test_reset_mid_burst();
        int c, rises;
        logic prev_stb;
        s_dly = 2; s_rel = 0;
        c = 0;
        while (!(o_cmd_rdy === 1'b1 && i_wbm_ack === 1'b0) && c < 60) begin
            @(negedge clk);
            c++;
        end
        i_cmd_stb = 1'b1; i_cmd_we = 1'b0; i_cmd_adr = 32'h5000; i_cmd_len = 16'd4;
        @(negedge clk);
        i_cmd_stb = 1'b0;
        rises = 0; prev_stb = 1'b0;
        for (c = 0; c < 100; c++) begin
            if (o_wbm_stb && !prev_stb) rises++;
            prev_stb = o_wbm_stb;
            if (rises == 2 && o_wbm_stb) break;
            @(negedge clk);
        end
        n_cmp++;
        if (rises != 2) begin
            n_err++;
            $display("FAIL rst_mid_reach: stb rises=%0d want 2", rises);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_cmd_rdy, o_wr_rdy, o_rd_vld, o_done, o_timeout, o_wbm_cyc, o_wbm_stb,
             o_wbm_we, o_int} !== 9'b0 || o_wbm_sel !== 4'h0 || o_wbm_adr !== 32'h0 ||
            o_wbm_dat !== 32'h0 || o_rd_dat !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: cyc=%b stb=%b adr=%h rd_dat=%h, want all 0",
                     o_wbm_cyc, o_wbm_stb, o_wbm_adr, o_rd_dat);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o_done !== 1'b0 || o_wbm_cyc !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_hold[%0d]: done=%b cyc=%b want 0 0", i, o_done, o_wbm_cyc);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o_done !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_no_done[%0d]: got %b want 0", i, o_done);
            end
        end
        n_cmp++;
        if (o_cmd_rdy !== 1'b1 || o_wbm_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_idle: rdy=%b cyc=%b want 1 0", o_cmd_rdy, o_wbm_cyc);
        end
    endtask

    initial begin
        i_cmd_stb = 1'b0; i_cmd_we = 1'b0; i_cmd_adr = 32'h0; i_cmd_len = 16'h0;
        i_wr_dat = 32'h0; i_wr_vld = 1'b0; i_wbm_int = 1'b0;
        clear_wdata();
        test_reset();
        test_single_write();
        test_burst_read();
        test_timeout();
        test_zero_len();
        test_wrap();
        test_write_gap();
        test_stuck_ack();
        test_int();
        test_back_to_back();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
